add_pipe: RTL and testbench

//  Signed adder, inverse of the existing subtractor. Pipelined behind valid/ready handshakes.

---
 rtl/add_pkg.sv | 9 +
 rtl/skid_buf.sv | 51 +++++
 rtl/add_pipe.sv | 87 ++++++++
 tb/tb_add_pipe.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Width rule shared by the adder and the matching subtractor: one guard bit
// above the wider operand keeps every sum or difference exact.
package add_pkg;

  function automatic int max_w(input int l1, input int l2);
    return ((l1 > l2) ? l1 : l2) + 1;
  endfunction

endpackage

// File: rtl/skid_buf.sv
// One-entry skid register. in_ready comes straight from a flop, so downstream
// ready never reaches upstream combinationally.
module skid_buf #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          skid_full_reg;
  logic          skid_full_next;
  logic [DW-1:0] skid_data_reg;
  logic          ready_reg;
  logic          accept;

  assign in_ready  = ready_reg;
  assign accept    = in_valid & ready_reg;
  assign out_valid = skid_full_reg | accept;
  assign out_data  = skid_full_reg ? skid_data_reg : in_data;

  // Nothing is accepted while full, so a full skid only waits to drain.
  always_comb begin
    skid_full_next = skid_full_reg;
    if (skid_full_reg) begin
      skid_full_next = !out_ready;
    end else begin
      skid_full_next = accept & !out_ready;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_full_reg <= 1'b0;
      skid_data_reg <= '0;
      ready_reg     <= 1'b0;
    end else begin
      skid_full_reg <= skid_full_next;
      ready_reg     <= !skid_full_next;
      if (!skid_full_reg && accept && !out_ready) begin
        skid_data_reg <= in_data;
      end
    end
  end

endmodule

// File: rtl/add_pipe.sv
// Exact signed adder, two register stages (operands, sum) behind a skid buffer.
// Each stage loads when it is empty or its content leaves in the same cycle.
module add_pipe
  import add_pkg::*;
#(
  parameter int L1 = 8,
  parameter int L2 = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [L1-1:0]           in1,
  input  logic [L2-1:0]           in2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [max_w(L1,L2)-1:0] out
);

  localparam int W  = max_w(L1, L2);
  localparam int DW = L1 + L2;

  logic          skid_valid;
  logic [DW-1:0] skid_data;
  logic [L1-1:0] d1;
  logic [L2-1:0] d2;
  logic [W-1:0]  a_next;
  logic [W-1:0]  b_next;

  logic          s0_valid_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          s1_valid_reg;
  logic [W-1:0]  sum_reg;
  logic          s0_ready;
  logic          s1_ready;

  skid_buf #(
    .DW(DW)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  ({in1, in2}),
    .out_valid(skid_valid),
    .out_ready(s0_ready),
    .out_data (skid_data)
  );

  assign d1     = skid_data[DW-1:L2];
  assign d2     = skid_data[L2-1:0];
  assign a_next = {{(W-L1){d1[L1-1]}}, d1};
  assign b_next = {{(W-L2){d2[L2-1]}}, d2};

  // An empty S1 accepts regardless of out_ready, so bubbles collapse.
  assign s1_ready = !s1_valid_reg | out_ready;
  assign s0_ready = !s0_valid_reg | s1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_reg <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      s1_valid_reg <= 1'b0;
      sum_reg      <= '0;
    end else begin
      if (s0_ready) begin
        s0_valid_reg <= skid_valid;
        if (skid_valid) begin
          a_reg <= a_next;
          b_reg <= b_next;
        end
      end
      if (s1_ready) begin
        s1_valid_reg <= s0_valid_reg;
        if (s0_valid_reg) begin
          sum_reg <= a_reg + b_reg;
        end
      end
    end
  end

  assign out_valid = s1_valid_reg;
  assign out       = sum_reg;

endmodule

// File: tb/tb_add_pipe.sv
// Directed bench for add_pipe: 8+8, 8+12 and 1+1 instances on one clock/reset.
module tb_add_pipe;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic       iv8, ir8, ov8, or8;
  logic [7:0] a8, b8;
  logic [8:0] o8;

  logic        iv12, ir12, ov12, or12;
  logic [7:0]  a12;
  logic [11:0] b12;
  logic [12:0] o12;

  logic       iv1, ir1, ov1, or1;
  logic [0:0] a1, b1;
  logic [1:0] o1;

  add_pipe #(.L1(8), .L2(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in1(a8), .in2(b8),
    .out_valid(ov8), .out_ready(or8), .out(o8)
  );

  add_pipe #(.L1(8), .L2(12)) u12 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv12), .in_ready(ir12), .in1(a12), .in2(b12),
    .out_valid(ov12), .out_ready(or12), .out(o12)
  );

  add_pipe #(.L1(1), .L2(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in1(a1), .in2(b1),
    .out_valid(ov1), .out_ready(or1), .out(o1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  localparam int N4 = 10000;

  logic [7:0] t2a [4] = '{8'd5, 8'hFC, 8'd127, 8'h80};
  logic [7:0] t2b [4] = '{8'd3, 8'd1, 8'd127, 8'h80};
  logic [8:0] t2e [4] = '{9'h008, 9'h1FD, 9'h0FE, 9'h100};

  logic [7:0] t3a [5] = '{8'd10, 8'hE2, 8'd100, 8'hF9, 8'd64};
  logic [7:0] t3b [5] = '{8'd20, 8'd5, 8'hFF, 8'hF8, 8'd64};
  logic [8:0] t3e [5] = '{9'h01E, 9'h1E7, 9'h063, 9'h1F1, 9'h080};

  logic [8:0] t5e [3] = '{9'h00B, 9'h1FE, 9'h012};

  initial begin
    int          acc;
    int          sent;
    int          rcvd;
    int          cyc;
    int          s;
    bit          ifire;
    bit          ofire;
    bit          hold;
    logic [12:0] hold_val;
    logic [12:0] e12;
    logic [8:0]  got[$];
    logic [12:0] q12[$];

    checks = 0;
    failures = 0;
    iv8 = 0; or8 = 0; a8 = 0; b8 = 0;
    iv12 = 0; or12 = 0; a12 = 0; b12 = 0;
    iv1 = 0; or1 = 0; a1 = 0; b1 = 0;

    // Power-on reset
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", ir8, 0);
    chk("rst_out_valid", ov8, 0);
    chk("rst_out", o8, 0);
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", ir8, 1);
    chk("rel_out_valid", ov8, 0);

    // Streaming with out_ready=1, including both extremes
    or8 = 1;
    for (int k = 0; k < 7; k++) begin
      if (k < 4) begin
        chk("s2_in_ready", ir8, 1);
        iv8 = 1; a8 = t2a[k]; b8 = t2b[k];
      end else begin
        iv8 = 0;
      end
      tick();
      if (k >= 1 && k <= 4) begin
        chk("s2_valid", ov8, 1);
        chk("s2_out", o8, t2e[k-1]);
      end else begin
        chk("s2_valid", ov8, 0);
      end
      $display("step2 cycle=%0d out_valid=%0d out=%0h", k, ov8, o8);
    end

    // Backpressure: 5 offered, 3 accepted, first sum held
    or8 = 0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      iv8 = 1; a8 = t3a[acc]; b8 = t3b[acc];
      ifire = ir8;
      tick();
      if (ifire) acc++;
      if (c >= 2) chk("s3_hold_out", o8, 9'h01E);
    end
    chk("s3_accepts", acc, 3);
    chk("s3_in_ready", ir8, 0);
    chk("s3_out_valid", ov8, 1);
    or8 = 1;
    got.delete();
    for (int c = 0; c < 20; c++) begin
      if (acc < 5) begin
        iv8 = 1; a8 = t3a[acc]; b8 = t3b[acc];
      end else begin
        iv8 = 0;
      end
      ofire = ov8 && or8;
      ifire = iv8 && ir8;
      if (ofire) got.push_back(o8);
      tick();
      if (ifire) acc++;
    end
    chk("s3_count", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      chk("s3_order", got[i], t3e[i]);
      $display("step3 result=%0d out=%0h", i, got[i]);
    end

    // Fill, free one slot, then accept and emit in the same cycle
    or8 = 0;
    iv8 = 1; a8 = 8'd1; b8 = 8'd2; tick();
    a8 = 8'd3; b8 = 8'd4; tick();
    a8 = 8'd5; b8 = 8'd6; tick();
    a8 = 8'hFF; b8 = 8'hFF;
    chk("s5_full", ir8, 0);
    chk("s5_head", o8, 9'h003);
    or8 = 1;
    tick();
    chk("s5_ready_back", ir8, 1);
    chk("s5_second", o8, 9'h007);
    tick();
    chk("s5_sim_out", o8, 9'h00B);
    chk("s5_sim_valid", ov8, 1);
    chk("s5_sim_ready", ir8, 1);
    or8 = 0;
    a8 = 8'd9; b8 = 8'd9;
    tick();
    chk("s5_one_more_fills", ir8, 0);
    iv8 = 0;
    or8 = 1;
    got.delete();
    for (int c = 0; c < 8; c++) begin
      if (ov8) got.push_back(o8);
      tick();
    end
    chk("s5_count", got.size(), 3);
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      chk("s5_order", got[i], t5e[i]);
      $display("step5 result=%0d out=%0h", i, got[i]);
    end

    // Random handshakes, L1=8 L2=12
    sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < N4 && cyc < 60000) begin
      if (!(iv12 && !ir12)) begin
        if (sent < N4 && $urandom_range(0, 3) != 0) begin
          iv12 = 1; a12 = 8'($urandom); b12 = 12'($urandom);
        end else begin
          iv12 = 0;
        end
      end
      or12 = ($urandom_range(0, 3) != 0);
      if (iv12 && ir12) begin
        s = int'($signed(a12)) + int'($signed(b12));
        q12.push_back(13'(s));
        sent++;
      end
      if (ov12 && or12) begin
        if (q12.size() == 0) begin
          chk("s4_spurious", 1, 0);
        end else begin
          e12 = q12.pop_front();
          chk("s4_out", o12, e12);
        end
        rcvd++;
      end
      hold = ov12 && !or12;
      hold_val = o12;
      tick();
      cyc++;
      if (hold) chk("s4_stable", {ov12, o12}, {1'b1, hold_val});
    end
    chk("s4_received", rcvd, N4);
    $display("step4 pairs=%0d cycles=%0d", rcvd, cyc);
    iv12 = 0; or12 = 0;

    // 1-bit operands
    or1 = 1;
    iv1 = 1; a1 = 1'b1; b1 = 1'b1; tick();
    a1 = 1'b0; b1 = 1'b1; tick();
    iv1 = 0;
    chk("s6_valid_a", ov1, 1);
    chk("s6_m1_m1", o1, 2'b10);
    tick();
    chk("s6_valid_b", ov1, 1);
    chk("s6_0_m1", o1, 2'b11);
    tick();
    chk("s6_empty", ov1, 0);

    // Reset with three pairs in flight
    or8 = 0;
    iv8 = 1; a8 = 8'd20; b8 = 8'd22; tick();
    a8 = 8'd1; b8 = 8'd1; tick();
    a8 = 8'd2; b8 = 8'd2; tick();
    iv8 = 0;
    chk("s1_full", ir8, 0);
    chk("s1_pre_valid", ov8, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("s1_async_valid", ov8, 0);
    chk("s1_async_ready", ir8, 0);
    chk("s1_async_out", o8, 0);
    tick();
    chk("s1_hold_ready", ir8, 0);
    rst_n = 1'b1;
    tick();
    chk("s1_rel_ready", ir8, 1);
    or8 = 1;
    for (int c = 0; c < 4; c++) begin
      chk("s1_no_stale", ov8, 0);
      tick();
    end
    iv8 = 1; a8 = 8'd2; b8 = 8'd2; tick();
    iv8 = 0; tick();
    chk("s1_after_valid", ov8, 1);
    chk("s1_after_out", o8, 9'h004);
    $display("step1 post-reset out_valid=%0d out=%0h", ov8, o8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
